bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the BCD digit adder and turns binary operands into packed BCD digits that the adder consumes. It uses a valid/ready handshake on both sides and holds one conversion in flight.

Parameters:
WIDTH, 8, bit width of the binary input; legal range >= 1.
DIGITS, 3, number of 4-bit BCD output digits; legal range >= 1.
CNTW, $clog2(WIDTH+1), width of the internal bit counter. Derived; not to be overridden.

Ports:
main_clk_i  input  1  clock; all flops rise-edge.
main_rst_an_i  input  1  asynchronous reset, active-low.
bin_i  input  WIDTH  binary operand; sampled on the accept edge only.
in_valid_i  input  1  bin_i is valid.
in_ready_o  output  1  block can accept a new operand.
bcd_o  output  4*DIGITS  packed BCD result; digit k is bits [4k+3:4k], digit 0 is least significant.
overflow_o  output  1  value exceeded 10^DIGITS-1; qualified by out_valid_o.
out_valid_o  output  1  bcd_o and overflow_o are valid.
out_ready_i  input  1  downstream takes the result.

Behaviour:
- Reset (async assert, sync release): state IDLE, shift registers 0, counter 0, overflow flag 0.
  - Reset values: in_ready_o=1, out_valid_o=0, bcd_o=0, overflow_o=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i && in_ready_o: load the binary shift reg with bin_i, clear the BCD reg and overflow flag, set counter=WIDTH, go to SHIFT.
- SHIFT (one bit per cycle):
  - First apply the per-digit correction to every BCD digit: a digit >=5 gets +3, a digit <=4 is unchanged.
  - Then shift {bcd, bin} left by 1. The MSB of the top corrected digit is shifted out; if it is 1, set the sticky overflow flag.
  - Decrement the counter. When the counter goes 1->0, go to DONE.
  - in_ready_o=0 and out_valid_o=0 throughout.
- DONE:
  - out_valid_o=1; bcd_o = BCD reg; overflow_o = flag.
  - Outputs stay stable until out_valid_o && out_ready_i.
  - On that handshake: if in_valid_i is also high, accept the new operand in the same cycle and go straight to SHIFT; otherwise go to IDLE.
  - in_ready_o = out_ready_i in DONE. This is a combinational path ready-in to ready-out; accepted.
- Latency: out_valid_o rises exactly WIDTH clock edges after the accepting edge.
- Throughput: one result per WIDTH+1 cycles with back-to-back traffic.
- Arithmetic: with overflow, bcd_o = value mod 10^DIGITS, still valid BCD. With DIGITS >= ceil(WIDTH*log10(2)), overflow_o is constant 0.
- Outside DONE, bcd_o holds the previous result. Consumers must qualify with out_valid_o.
- in_valid_i high in SHIFT: ignored; the operand is not consumed (in_ready_o=0).
- bin_i changing after the accept edge: no effect.
- Reset mid-conversion: the conversion is aborted immediately; no result is emitted after release.
- WIDTH=1: a single SHIFT cycle.

Decomposition:
- Package bin2bcd_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - constants BCD_CORR_THRESH=4'd5 and BCD_CORR_ADD=4'd3.
  - function digits_needed(width) for parameter checks.
- Sub-module bin2bcd_digit_corr: combinational; 4-bit in, 4-bit out (add 3 if >=5). Instantiated DIGITS times via generate.
- Elaboration check: WIDTH>=1 and DIGITS>=1; otherwise fatal.

Test Plan:
- Reset, then WIDTH=8/DIGITS=3, bin_i=8'd255 accepted at edge t -> out_valid_o at t+8, bcd_o=12'h255, overflow_o=0.
- bin_i=0, then bin_i=8'd99 -> bcd_o=12'h000, then 12'h099, both with overflow_o=0.
- out_ready_i held low 5 cycles in DONE -> bcd_o, overflow_o and out_valid_o stable; in_ready_o=0; in_valid_i pulses are not consumed.
- WIDTH=8/DIGITS=2, bin_i=8'd200 -> bcd_o=8'h00, overflow_o=1. Then bin_i=8'd42 -> bcd_o=8'h42, overflow_o=0 (sticky flag cleared on load).
- Back-to-back: in_valid_i held with 37, 128, 9 and out_ready_i=1 -> results 037, 128, 009 at 9-cycle spacing, no drops or duplicates.
- main_rst_an_i pulsed low mid-SHIFT (counter=4) -> outputs return to reset values immediately, no spurious out_valid_o after release, and the next conversion is correct.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types, correction constants and sizing helper for the BCD converter
package bin2bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  localparam bcd_digit_t BCD_CORR_THRESH = 4'd5;
  localparam bcd_digit_t BCD_CORR_ADD = 4'd3;
  // Decimal digits needed for 2^width-1, i.e. ceil(width*log10(2)) in fixed point.
  function automatic int digits_needed(input int width);
    return int'((longint'(width) * 64'sd30103 + 64'sd99999) / 64'sd100000);
  endfunction
endpackage

// File: rtl/bin2bcd_digit_corr.sv
// bin2bcd_digit_corr: double-dabble digit correction, adds 3 to a digit >= 5
//   i_digit : BCD digit before the shift
//   o_digit : corrected digit
module bin2bcd_digit_corr
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);
  assign o_digit = (i_digit >= BCD_CORR_THRESH) ? i_digit + BCD_CORR_ADD : i_digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to packed BCD converter, one bit per clock
//   main_clk_i    : clock, rising edge
//   main_rst_an_i : asynchronous reset, active low
//   bin_i         : binary operand, sampled on the accept edge
//   in_valid_i    : operand valid
//   in_ready_o    : converter can accept an operand
//   bcd_o         : packed BCD result, digit 0 in the low nibble
//   overflow_o    : value exceeded 10^DIGITS-1
//   out_valid_o   : bcd_o/overflow_o valid
//   out_ready_i   : downstream takes the result
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                main_clk_i,
  input  logic                main_rst_an_i,
  input  logic [WIDTH-1:0]    bin_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                overflow_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);
  import bin2bcd_pkg::*;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  // With enough digits the shifted-out bit is provably always 0.
  localparam bit OVF_POSSIBLE = DIGITS < digits_needed(WIDTH);
  if (WIDTH < 1 || DIGITS < 1) begin : g_param_err
    $fatal(1, "bin2bcd_seq: WIDTH and DIGITS must both be >= 1");
  end
  state_t            r_state, w_next;
  logic [WIDTH-1:0]  r_bin;
  logic [BW-1:0]     r_bcd, r_res, w_corr, w_bcd_sh;
  logic [CNTW-1:0]   r_cnt;
  logic              r_ovf, r_res_ovf, w_ovf_sh, w_last, w_accept;
  for (genvar k = 0; k < DIGITS; k++) begin : g_corr
    bin2bcd_digit_corr u_corr (
      .i_digit(r_bcd[4*k +: 4]),
      .o_digit(w_corr[4*k +: 4])
    );
  end
  // The top bit of the corrected BCD word falls off the end of the shift; any 1 there means overflow.
  assign w_bcd_sh = {w_corr[BW-2:0], r_bin[WIDTH-1]};
  assign w_ovf_sh = r_ovf | w_corr[BW-1];
  assign w_last   = r_cnt == CNTW'(1);
  assign w_accept = in_valid_i && in_ready_o;
  always_ff @(posedge main_clk_i or negedge main_rst_an_i)
    if (!main_rst_an_i) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next = w_accept ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: w_next = w_last ? ST_DONE : ST_SHIFT;
      ST_DONE:  w_next = w_accept ? ST_SHIFT : out_ready_i ? ST_IDLE : ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_comb begin
    in_ready_o  = (r_state == ST_IDLE) || (r_state == ST_DONE && out_ready_i);
    out_valid_o = r_state == ST_DONE;
    bcd_o       = r_res;
    overflow_o  = r_res_ovf & OVF_POSSIBLE;
  end
  // The result register is separate from the shift register so bcd_o holds the last result while shifting.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i)
    if (!main_rst_an_i) begin
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_res     <= '0;
      r_res_ovf <= 1'b0;
    end else if (w_accept) begin
      r_bin <= bin_i;
      r_bcd <= '0;
      r_cnt <= CNTW'(WIDTH);
      r_ovf <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      r_bin <= r_bin << 1;
      r_bcd <= w_bcd_sh;
      r_cnt <= r_cnt - 1'b1;
      r_ovf <= w_ovf_sh;
      if (w_last) begin
        r_res     <= w_bcd_sh;
        r_res_ovf <= w_ovf_sh;
      end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed bench for bin2bcd_seq with a 3-digit and a 2-digit instance sharing inputs
module tb_bin2bcd_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] bin = '0;
  logic ir3, ov3, of3, ir2, ov2, of2;
  logic [11:0] bcd3;
  logic [7:0] bcd2;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut3 (
    .main_clk_i(clk), .main_rst_an_i(rst_n), .bin_i(bin), .in_valid_i(in_valid),
    .in_ready_o(ir3), .bcd_o(bcd3), .overflow_o(of3), .out_valid_o(ov3), .out_ready_i(out_ready)
  );
  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
    .main_clk_i(clk), .main_rst_an_i(rst_n), .bin_i(bin), .in_valid_i(in_valid),
    .in_ready_o(ir2), .bcd_o(bcd2), .overflow_o(of2), .out_valid_o(ov2), .out_ready_i(out_ready)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [7:0] v);
    bin = v;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    bin = ~v;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!ov3 && lat < 30) begin
      step;
      lat++;
    end
  endtask
  task automatic consume;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) step;
    n_chk++; if (ir3 !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", ir3); else n_pass++;
    n_chk++; if (ov3 !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", ov3); else n_pass++;
    n_chk++; if (bcd3 !== 12'h000) $display("FAIL rst_bcd got %h exp 000", bcd3); else n_pass++;
    n_chk++; if (of2 !== 1'b0) $display("FAIL rst_overflow got %b exp 0", of2); else n_pass++;
    n_chk++; if (ir2 !== 1'b1 || ov2 !== 1'b0) $display("FAIL rst_dut2 got ir=%b ov=%b exp ir=1 ov=0", ir2, ov2); else n_pass++;
    rst_n = 1'b1;
    step;
  endtask
  task automatic test_basic;
    int lat;
    accept(8'd255);
    wait_valid(lat);
    n_chk++; if (lat !== 8) $display("FAIL basic_latency got %0d exp 8", lat); else n_pass++;
    n_chk++; if (bcd3 !== 12'h255) $display("FAIL basic_bcd got %h exp 255", bcd3); else n_pass++;
    n_chk++; if (of3 !== 1'b0) $display("FAIL basic_ovf got %b exp 0", of3); else n_pass++;
    n_chk++; if (bcd2 !== 8'h55 || of2 !== 1'b1) $display("FAIL basic_d2 got %h/%b exp 55/1", bcd2, of2); else n_pass++;
    consume;
  endtask
  task automatic test_zero_99;
    int lat;
    accept(8'd0);
    repeat (2) step;
    n_chk++; if (bcd3 !== 12'h255) $display("FAIL hold_prev_bcd got %h exp 255", bcd3); else n_pass++;
    n_chk++; if (ov3 !== 1'b0 || ir3 !== 1'b0) $display("FAIL shift_flags got ov=%b ir=%b exp 0 0", ov3, ir3); else n_pass++;
    wait_valid(lat);
    n_chk++; if (bcd3 !== 12'h000 || of3 !== 1'b0) $display("FAIL zero_bcd got %h/%b exp 000/0", bcd3, of3); else n_pass++;
    n_chk++; if (bcd2 !== 8'h00 || of2 !== 1'b0) $display("FAIL zero_d2 got %h/%b exp 00/0", bcd2, of2); else n_pass++;
    consume;
    accept(8'd99);
    wait_valid(lat);
    n_chk++; if (bcd3 !== 12'h099 || of3 !== 1'b0) $display("FAIL n99_bcd got %h/%b exp 099/0", bcd3, of3); else n_pass++;
    n_chk++; if (bcd2 !== 8'h99 || of2 !== 1'b0) $display("FAIL n99_d2 got %h/%b exp 99/0", bcd2, of2); else n_pass++;
    consume;
  endtask
  task automatic test_stall;
    int lat;
    accept(8'd123);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      bin = 8'd55;
      #1;
      n_chk++; if (ov3 !== 1'b1) $display("FAIL stall_valid cyc %0d got %b exp 1", i, ov3); else n_pass++;
      n_chk++; if (bcd3 !== 12'h123 || of3 !== 1'b0) $display("FAIL stall_bcd cyc %0d got %h/%b exp 123/0", i, bcd3, of3); else n_pass++;
      n_chk++; if (bcd2 !== 8'h23 || of2 !== 1'b1) $display("FAIL stall_d2 cyc %0d got %h/%b exp 23/1", i, bcd2, of2); else n_pass++;
      n_chk++; if (ir3 !== 1'b0) $display("FAIL stall_in_ready cyc %0d got %b exp 0", i, ir3); else n_pass++;
      step;
    end
    in_valid = 1'b0;
    consume;
    n_chk++; if (ov3 !== 1'b0 || ir3 !== 1'b1) $display("FAIL stall_release got ov=%b ir=%b exp 0 1", ov3, ir3); else n_pass++;
  endtask
  task automatic test_overflow;
    int lat;
    accept(8'd200);
    wait_valid(lat);
    n_chk++; if (bcd2 !== 8'h00 || of2 !== 1'b1) $display("FAIL ovf200_d2 got %h/%b exp 00/1", bcd2, of2); else n_pass++;
    n_chk++; if (bcd3 !== 12'h200 || of3 !== 1'b0) $display("FAIL ovf200_d3 got %h/%b exp 200/0", bcd3, of3); else n_pass++;
    consume;
    accept(8'd42);
    wait_valid(lat);
    n_chk++; if (bcd2 !== 8'h42 || of2 !== 1'b0) $display("FAIL sticky_clear got %h/%b exp 42/0", bcd2, of2); else n_pass++;
    consume;
  endtask
  task automatic test_back_to_back;
    logic [7:0] vals [3];
    logic [11:0] res [4];
    logic [11:0] exp_res [3];
    int tim [4];
    int n_acc, n_res;
    logic acc;
    vals = '{8'd37, 8'd128, 8'd9};
    exp_res = '{12'h037, 12'h128, 12'h009};
    n_acc = 0;
    n_res = 0;
    bin = vals[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc = ir3 && in_valid;
      step;
      if (acc) begin
        n_acc++;
        if (n_acc < 3) bin = vals[n_acc];
        else in_valid = 1'b0;
      end
      if (ov3 && n_res < 4) begin
        res[n_res] = bcd3;
        tim[n_res] = c;
        n_res++;
      end
    end
    out_ready = 1'b0;
    n_chk++; if (n_res !== 3) $display("FAIL b2b_count got %0d exp 3", n_res); else n_pass++;
    for (int i = 0; i < 3; i++)
      if (i < n_res) begin
        n_chk++; if (res[i] !== exp_res[i]) $display("FAIL b2b_res%0d got %h exp %h", i, res[i], exp_res[i]); else n_pass++;
      end
    if (n_res >= 3) begin
      n_chk++; if (tim[1] - tim[0] !== 9 || tim[2] - tim[1] !== 9) $display("FAIL b2b_spacing got %0d,%0d exp 9,9", tim[1] - tim[0], tim[2] - tim[1]); else n_pass++;
    end
  endtask
  task automatic test_reset_mid;
    int lat, seen;
    accept(8'd77);
    repeat (4) step;
    rst_n = 1'b0;
    #1;
    n_chk++; if (ov3 !== 1'b0 || ir3 !== 1'b1) $display("FAIL midrst_flags got ov=%b ir=%b exp 0 1", ov3, ir3); else n_pass++;
    n_chk++; if (bcd3 !== 12'h000 || of3 !== 1'b0) $display("FAIL midrst_bcd got %h/%b exp 000/0", bcd3, of3); else n_pass++;
    n_chk++; if (bcd2 !== 8'h00 || of2 !== 1'b0) $display("FAIL midrst_d2 got %h/%b exp 00/0", bcd2, of2); else n_pass++;
    repeat (2) step;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      step;
      if (ov3 || ov2) seen++;
    end
    n_chk++; if (seen !== 0) $display("FAIL midrst_spurious got %0d valid cycles exp 0", seen); else n_pass++;
    accept(8'd250);
    wait_valid(lat);
    n_chk++; if (lat !== 8) $display("FAIL postrst_latency got %0d exp 8", lat); else n_pass++;
    n_chk++; if (bcd3 !== 12'h250 || of3 !== 1'b0) $display("FAIL postrst_bcd got %h/%b exp 250/0", bcd3, of3); else n_pass++;
    n_chk++; if (bcd2 !== 8'h50 || of2 !== 1'b1) $display("FAIL postrst_d2 got %h/%b exp 50/1", bcd2, of2); else n_pass++;
    consume;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_zero_99;
    test_stall;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end
endmodule
